// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with pixel clock-enable and registered outputs.
// Optional lookahead read-address outputs are enabled by defining VGA_TIMING_LOOKAHEAD_EN.
module vga_timing_gen #(
  parameter int H_SYNC  = 120,
  parameter int H_BACK  = 64,
  parameter int H_DISP  = 800,
  parameter int H_FRONT = 56,
  parameter int V_SYNC  = 6,
  parameter int V_BACK  = 23,
  parameter int V_DISP  = 600,
  parameter int V_FRONT = 37,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] xpos,
  output logic [CW-1:0] ypos,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_LOOKAHEAD_EN
  ,
  output logic          nx_de,
  output logic [CW-1:0] nx_xpos,
  output logic [CW-1:0] nx_ypos
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int HA      = H_SYNC + H_BACK;
  localparam int VA      = V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] HA_C     = CW'(HA);
  localparam logic [CW-1:0] VA_C     = CW'(VA);
  localparam logic [CW-1:0] HE_C     = CW'(HA + H_DISP);
  localparam logic [CW-1:0] VE_C     = CW'(VA + V_DISP);
  localparam logic          HS_ACT   = (HS_POL != 0);
  localparam logic          VS_ACT   = (VS_POL != 0);

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic          cur_de;
  logic [CW-1:0] cur_x;
  logic [CW-1:0] cur_y;

  // Window decode of the current counters; coordinates are forced to 0 outside it.
  always_comb begin
    cur_de = (hc >= HA_C) && (hc < HE_C) && (vc >= VA_C) && (vc < VE_C);
    cur_x  = cur_de ? (hc - HA_C) : '0;
    cur_y  = cur_de ? (vc - VA_C) : '0;
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  assign nx_de   = cur_de;
  assign nx_xpos = cur_x;
  assign nx_ypos = cur_y;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (pix_en) begin
      if (hc == H_LAST) begin
        hc <= '0;
        vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  // Outputs capture the pre-increment position, so they trail the counters by one tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs          <= ~HS_ACT;
      vs          <= ~VS_ACT;
      de          <= 1'b0;
      xpos        <= '0;
      ypos        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hs          <= (hc < H_SYNC_C) ? HS_ACT : ~HS_ACT;
        vs          <= (vc < V_SYNC_C) ? VS_ACT : ~VS_ACT;
        de          <= cur_de;
        xpos        <= cur_x;
        ypos        <= cur_y;
        line_start  <= (hc == '0);
        frame_start <= (hc == '0) && (vc == '0);
      end
    end
  end

endmodule
